// File: rtl/fetch_unit.sv
// Instruction fetch: holds fetch PC, issues one-outstanding imem requests, queues {word, pc} for decode.
// Latency: rvalid in cycle N -> instr_valid in N+1 when the queue was empty; 1 instr / 2 cycles best case.
// Backpressure: a request is issued only with a free queue slot reserved; head held while valid && !ready.
module fetch_unit #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           DEPTH      = 2,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_gnt,
  input  logic                  imem_rvalid,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [DATA_WIDTH-1:0] instr_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  state_e                state_q;
  logic [DATA_WIDTH-1:0] pc_q;
  logic [DATA_WIDTH-1:0] issued_pc_q;
  logic                  drop_q;

  logic [DATA_WIDTH-1:0] mem_instr_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_pc_q    [DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;

  logic                  issue;
  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] redirect_pc_al;
  logic                  unused_pc_lsbs;

  // The two low target bits carry no information for word fetch.
  assign redirect_pc_al = {redirect_pc[DATA_WIDTH-1:2], 2'b00};
  assign unused_pc_lsbs = ^redirect_pc[1:0];

  // While in REQ nothing is outstanding, so count < DEPTH is exactly "one slot free for the reply".
  assign imem_req  = (state_q == S_REQ) && (count_q < DEPTH_C);
  assign imem_addr = pc_q;
  assign issue     = imem_req && imem_gnt;

  // A redirect voids both the reply landing this cycle and any head consumption.
  assign push = (state_q == S_WAIT) && imem_rvalid && !drop_q && !redirect;
  assign pop  = instr_valid && instr_ready && !redirect;

  assign instr_valid = (count_q != '0);
  assign instr       = instr_valid ? mem_instr_q[rd_ptr_q] : '0;
  assign instr_pc    = instr_valid ? mem_pc_q[rd_ptr_q]    : '0;

  // Fetch FSM: PC advance on issue, drop flag marks an in-flight reply orphaned by a redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      issued_pc_q <= '0;
      drop_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_q <= S_REQ;
          if (redirect) pc_q <= redirect_pc_al;
        end
        S_REQ: begin
          if (redirect) begin
            pc_q <= redirect_pc_al;
            if (issue) begin
              state_q <= S_WAIT;
              drop_q  <= 1'b1;
            end
          end else if (issue) begin
            pc_q        <= pc_q + DATA_WIDTH'(4);
            issued_pc_q <= pc_q;
            state_q     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (redirect) begin
            pc_q <= redirect_pc_al;
            if (imem_rvalid) begin
              state_q <= S_REQ;
              drop_q  <= 1'b0;
            end else begin
              drop_q  <= 1'b1;
            end
          end else if (imem_rvalid) begin
            state_q <= S_REQ;
            drop_q  <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Queue pointer/occupancy next state; redirect empties the queue.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (redirect) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
  end

  // Queue pointer/occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Queue storage; contents are only visible through instr_valid, so no reset is needed.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_instr_q[wr_ptr_q] <= imem_rdata;
      mem_pc_q[wr_ptr_q]    <= issued_pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised bench for fetch_unit: bench-side memory responder plus a program-order model of the
// instruction stream (sequential PCs, restarted at every redirect/reset), checked by a negedge monitor.
// The monitor also checks reset values, request hold, head hold, flush and fill latency.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'hFFFF_FFFC;

  logic        clk;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;

  fetch_unit #(.DATA_WIDTH(32), .DEPTH(2), .RESET_PC(RST_PC)) dut (
    .clk        (clk),
    .rst        (rst),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Knobs for the driver
  int gnt_pct = 100, rdy_pct = 100, dly_min = 0, dly_max = 0, redir_permil = 0;
  bit rst_req = 1'b1;
  bit keep_stale = 1'b0;

  // Memory responder state (bench-side, one outstanding)
  bit          pend = 1'b0;
  int          pdelay = 0;
  logic [31:0] paddr = '0;
  bit          pstale = 1'b0;
  bit          prev_rst_drv = 1'b0;
  bit          good_rsp = 1'b0;

  // Expected program-order stream of PCs to reach decode
  logic [31:0] exp_q[$];

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5EED_C0DE;
  endfunction

  function automatic logic [31:0] rnd_target();
    if ($urandom_range(3) == 0) return 32'hFFFF_FFF0 | 32'($urandom_range(15));
    return $urandom;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic restart(input logic [31:0] a);
    exp_q.delete();
    exp_q.push_back(a);
  endtask

  task automatic drive_cycle(input bit frc_redir = 1'b0, input logic [31:0] tgt = '0,
                             input int frc_rdy = -1);
    bit got;
    bit rsp_stale;
    bit issued;
    @(posedge clk);
    #1;
    rst         = rst_req;
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    got         = 1'b0;
    rsp_stale   = 1'b1;
    if (rst) begin
      if (!keep_stale) pend = 1'b0;
    end else begin
      // A reply to a pre-reset request landing in the first post-reset cycle
      if (prev_rst_drv && keep_stale && pend) begin
        pdelay = 0;
        pstale = 1'b1;
      end
      keep_stale = 1'b0;
      if (pend) begin
        if (pdelay == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = word_of(paddr);
          rsp_stale   = pstale;
          pend        = 1'b0;
          got         = 1'b1;
        end else begin
          pdelay--;
        end
      end
    end
    prev_rst_drv = rst;
    imem_gnt    = ($urandom_range(99) < gnt_pct);
    instr_ready = (frc_rdy >= 0) ? (frc_rdy != 0) : ($urandom_range(99) < rdy_pct);
    redirect    = !rst && (frc_redir || ($urandom_range(999) < redir_permil));
    redirect_pc = frc_redir ? tgt : rnd_target();
    issued      = !rst && imem_req && imem_gnt;
    if (redirect && pend) pstale = 1'b1;
    if (issued) begin
      pend   = 1'b1;
      paddr  = imem_addr;
      pdelay = $urandom_range(dly_max, dly_min);
      pstale = redirect;
    end
    good_rsp = got && !rsp_stale && !redirect;
    if (rst) restart(RST_PC);
    else if (redirect) restart({redirect_pc[31:2], 2'b00});
    while (exp_q.size() < 8) exp_q.push_back(exp_q[$] + 32'd4);
  endtask

  // Monitor: decoupled from the driver, samples mid-cycle
  logic [31:0] exp_addr = RST_PC;
  int          rst_cycles = 0;
  bit          p_rst = 1'b1, p_valid = 1'b0, p_ready = 1'b0, p_redir = 1'b0, p_good = 1'b0;
  bit          p_req = 1'b0, p_gnt = 1'b0;
  logic [31:0] p_addr = '0, p_instr = '0, p_pc = '0;

  always @(negedge clk) begin
    logic [31:0] e;
    if (rst) begin
      rst_cycles++;
      exp_addr = RST_PC;
      if (rst_cycles >= 2) begin
        chk("rst_req",   32'(imem_req), 32'd0);
        chk("rst_addr",  imem_addr, RST_PC);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_pc",    instr_pc, 32'd0);
      end
    end else begin
      rst_cycles = 0;
      if (p_rst) begin
        chk("idle_req",   32'(imem_req), 32'd0);
        chk("idle_addr",  imem_addr, RST_PC);
        chk("idle_valid", 32'(instr_valid), 32'd0);
      end else begin
        if (p_redir) chk("flush_valid", 32'(instr_valid), 32'd0);
        else if (!p_valid) chk("fill_latency", 32'(instr_valid), 32'(p_good));
        if (p_valid && !p_ready && !p_redir) begin
          chk("hold_valid", 32'(instr_valid), 32'd1);
          chk("hold_instr", instr, p_instr);
          chk("hold_pc",    instr_pc, p_pc);
        end
        if (p_req && !p_gnt && !p_redir) begin
          chk("req_hold", 32'(imem_req), 32'd1);
          chk("addr_hold", imem_addr, p_addr);
        end
      end
      chk("addr_align", 32'(imem_addr[1:0]), 32'd0);
      if (imem_req && imem_gnt) begin
        chk("issue_addr", imem_addr, exp_addr);
        exp_addr = exp_addr + 32'd4;
      end
      if (redirect) exp_addr = {redirect_pc[31:2], 2'b00};
      if (instr_valid && instr_ready && !redirect) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL stream: unexpected instr pc %h", instr_pc);
        end else begin
          e = exp_q.pop_front();
          chk("instr_pc", instr_pc, e);
          chk("instr",    instr, word_of(e));
        end
      end
    end
    p_rst   = rst;
    p_valid = instr_valid;
    p_ready = instr_ready;
    p_redir = redirect;
    p_good  = good_rsp;
    p_req   = imem_req;
    p_gnt   = imem_gnt;
    p_addr  = imem_addr;
    p_instr = instr;
    p_pc    = instr_pc;
  end

  task automatic wait_for_wait_state(input string name, input bit want_zero_delay, input bit need_valid);
    bit ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (pend && (want_zero_delay ? (pdelay == 0) : (pdelay > 0)) && (!need_valid || instr_valid)) begin
        ok = 1'b1;
        break;
      end
      drive_cycle();
    end
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: condition not reached within 60 cycles", name);
    end
  endtask

  initial begin
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; imem_gnt = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
    restart(RST_PC);

    // Reset, then streaming with an always-granting 1-cycle memory (wraps through 0)
    repeat (3) drive_cycle();
    rst_req = 1'b0;
    repeat (40) drive_cycle();

    // Decode stall: queue fills to DEPTH and requests stop
    rdy_pct = 0;
    repeat (20) drive_cycle();
    chk("stall_req_low", 32'(imem_req), 32'd0);
    chk("stall_valid",   32'(instr_valid), 32'd1);
    rdy_pct = 100;
    repeat (10) drive_cycle();

    // Grant withheld: request held, queue drains
    gnt_pct = 0;
    repeat (5) drive_cycle();
    chk("nognt_req",   32'(imem_req), 32'd1);
    chk("nognt_valid", 32'(instr_valid), 32'd0);
    gnt_pct = 100;
    repeat (10) drive_cycle();

    // Redirect while waiting; the late reply must be dropped
    dly_min = 3; dly_max = 3;
    wait_for_wait_state("redir_wait_setup", 1'b0, 1'b0);
    drive_cycle(1'b1, 32'h0000_0100);
    repeat (20) drive_cycle();

    // Redirect coinciding with rvalid and a head pop
    dly_min = 1; dly_max = 1; rdy_pct = 0;
    wait_for_wait_state("redir_rvalid_setup", 1'b1, 1'b1);
    drive_cycle(1'b1, 32'h0000_0203, 1);
    drive_cycle();
    chk("redir_flush_empty", 32'(instr_valid), 32'd0);
    rdy_pct = 100;
    repeat (20) drive_cycle();

    // Reset in WAIT with the old reply arriving in the first post-reset cycle
    dly_min = 3; dly_max = 3;
    wait_for_wait_state("rst_wait_setup", 1'b0, 1'b0);
    rst_req = 1'b1; keep_stale = 1'b1;
    repeat (3) drive_cycle();
    rst_req = 1'b0;
    repeat (30) drive_cycle();

    // Random traffic
    gnt_pct = 70; rdy_pct = 60; dly_min = 0; dly_max = 3; redir_permil = 40;
    repeat (3000) drive_cycle();

    // Drain quietly
    gnt_pct = 100; rdy_pct = 100; redir_permil = 0;
    repeat (20) drive_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
